div_32by16_seq: RTL and testbench

- Sequential restoring divider: N-bit unsigned dividend by D-bit unsigned divisor.
- Produces the quotient and remainder at one quotient bit per clock.
- Inverse companion to the team's shift-add 16-bit multiplier. Shares its start/done style of handshake and sits beside it in the arithmetic datapath.
- Used where a divide is needed without spending a combinational array.

---
 rtl/arith_pkg.sv | 22 ++
 rtl/div_step.sv | 25 ++
 rtl/div_32by16_seq.sv | 141 ++++++++++++++
 tb/tb_div_32by16_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM states, default
// operand widths and a constant-width helper used to size counters.
package arith_pkg;

  localparam int DIV_N = 32;
  localparam int DIV_D = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_step
  import arith_pkg::*;
#(
  parameter int D = DIV_D
) (
  input  logic [D:0]   r,
  input  logic         q_msb,
  input  logic [D-1:0] m,
  output logic [D:0]   r_next,
  output logic         q_bit
);

  logic [D:0] r_shift;
  logic [D:0] diff;

  // The shifted-out r[D] would make the true value exceed any divisor, so it
  // forces a successful subtract; the borrow bit diff[D] decides otherwise.
  assign r_shift = {r[D-1:0], q_msb};
  assign diff    = r_shift - {1'b0, m};
  assign q_bit   = r[D] | ~diff[D];
  assign r_next  = q_bit ? diff : r_shift;

endmodule

// File: rtl/div_32by16_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done
// handshake. Define DIV_SIGNED_EN for two's-complement operands.
module div_32by16_seq
  import arith_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int D = DIV_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         dbz
);

  localparam int CW = clog2(N);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_FIN  = FIN;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [D:0]    r_q;
  logic [N-1:0]  q_q;
  logic [D-1:0]  m_q;
  logic          dbz_pend;

  logic [D:0]    r_next;
  logic          q_bit;

  logic [N-1:0]  a_mag;
  logic [D-1:0]  b_mag;
  logic [N-1:0]  q_final;
  logic [D-1:0]  r_final;
  logic          divisor_zero;

  assign divisor_zero = (divisor == '0);

  div_step #(.D(D)) u_step (
    .r      (r_q),
    .q_msb  (q_q[N-1]),
    .m      (m_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

`ifdef DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;

  // Magnitudes feed the unsigned core; -2^(N-1) maps to 2^(N-1) unchanged.
  assign a_mag   = dividend[N-1] ? -dividend : dividend;
  assign b_mag   = divisor[D-1]  ? -divisor  : divisor;
  assign q_final = q_neg ? -q_q : q_q;
  assign r_final = r_neg ? -r_q[D-1:0] : r_q[D-1:0];
`else
  assign a_mag   = dividend;
  assign b_mag   = divisor;
  assign q_final = q_q;
  assign r_final = r_q[D-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      dbz_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_SIGNED_EN
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      // NOTE: done defaults low every cycle and only FIN raises it, so it is a
      // single-cycle pulse without a separate clear path; all state uses <=.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // On divide-by-zero Q keeps the raw dividend so FIN can echo it.
            q_q      <= divisor_zero ? dividend : a_mag;
            m_q      <= b_mag;
            r_q      <= '0;
            cnt      <= CW'(N - 1);
            busy     <= 1'b1;
            dbz_pend <= divisor_zero;
`ifdef DIV_SIGNED_EN
            q_neg    <= dividend[N-1] ^ divisor[D-1];
            r_neg    <= dividend[N-1];
`endif
            state    <= divisor_zero ? ST_FIN : ST_CALC;
          end
        end

        ST_CALC: begin
          q_q <= {q_q[N-2:0], q_bit};
          r_q <= r_next;
          if (cnt == '0) begin
            state <= ST_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_FIN: begin
          if (dbz_pend) begin
            quotient  <= '1;
            remainder <= q_q[D-1:0];
            dbz       <= 1'b1;
          end else begin
            quotient  <= q_final;
            remainder <= r_final;
            dbz       <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32by16_seq.sv
// Self-checking bench for div_32by16_seq: directed cases, handshake timing,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_div_32by16_seq;

  localparam int N = 32;
  localparam int D = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [D-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
  logic         dbz;

  int n_assert = 0;
  int n_fail   = 0;

  div_32by16_seq #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; signed build uses 64-bit signed math,
  // which truncates toward zero and gives the remainder the dividend's sign.
  task automatic ref_div(input logic [N-1:0] a, input logic [D-1:0] b,
                         output logic [N-1:0] q, output logic [D-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a[D-1:0];
    end else begin
`ifdef DIV_SIGNED_EN
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = N'(sa / sb);
      r  = D'(sa % sb);
`else
      q = a / N'(b);
      r = D'(a % N'(b));
`endif
    end
  endtask

  // Runs one operation, checking busy/done every cycle and the result on the
  // done cycle. poke_at re-pulses start mid-operation; hold keeps start high.
  task automatic do_op(input logic [N-1:0] a, input logic [D-1:0] b,
                       input string tag, input int poke_at, input bit hold);
    logic [N-1:0] eq;
    logic [D-1:0] er;
    int lat;
    ref_div(a, b, eq, er);
    lat = (b == '0) ? 1 : N + 1;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = hold;
    dividend = $urandom;
    divisor  = D'($urandom);
    check({tag, " busy_after_accept"}, {62'd0, busy, done}, 64'd2);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = hold || (k == poke_at);
      if (hold && k == lat) begin
        dividend = a;
        divisor  = b;
      end
      if (k < lat) begin
        check($sformatf("%s busy_c%0d", tag, k), {62'd0, busy, done}, 64'd2);
      end else begin
        check({tag, " done_busy"}, {62'd0, busy, done}, 64'd1);
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " dbz"}, 64'(dbz), 64'(b == '0));
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (hold) begin
      check({tag, " b2b_accept"}, {62'd0, busy, done}, 64'd2);
      repeat (lat - 1) @(negedge clk);
      @(negedge clk);
      check({tag, " b2b_done"}, {62'd0, busy, done}, 64'd1);
      check({tag, " b2b_quotient"}, 64'(quotient), 64'(eq));
      check({tag, " b2b_remainder"}, 64'(remainder), 64'(er));
    end else begin
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    logic [N-1:0] a;
    logic [D-1:0] b;
    int           done_seen;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset busy_done_dbz", {61'd0, busy, done, dbz}, 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    rst_n = 1'b1;

    do_op(32'd100, 16'd7, "div_100_7", -1, 1'b0);
    do_op(32'hFFFF_FFFF, 16'd1, "div_by_one", -1, 1'b0);
    do_op(32'd5, 16'd10, "small_dividend", -1, 1'b0);
    do_op(32'd1000, 16'd0, "div_by_zero", -1, 1'b0);
    do_op(32'd100, 16'd7, "start_ignored", 10, 1'b0);
    do_op(32'h8000_0000, 16'hFFFF, "msb_dividend", -1, 1'b0);

    // Abort an operation with an asynchronous reset partway through.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy_done_dbz", {61'd0, busy, done, dbz}, 64'd0);
    check("abort quotient", 64'(quotient), 64'd0);
    check("abort remainder", 64'(remainder), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort no_done", 64'(done_seen), 64'd0);
    do_op(32'd81, 16'd9, "after_reset", -1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      if (i % 3 == 0) a = a >> $urandom_range(8, 31);
      b = D'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      do_op(a, b, $sformatf("rand%0d", i), -1, 1'b0);
    end

    do_op(32'h1234_5678, 16'h00AB, "start_held", -1, 1'b1);

`ifdef DIV_SIGNED_EN
    do_op(-32'sd7, 16'd2, "signed_neg_dividend", -1, 1'b0);
    do_op(32'd7, -16'sd2, "signed_neg_divisor", -1, 1'b0);
    do_op(32'h8000_0000, 16'hFFFF, "signed_overflow", -1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
